sys44_seq: RTL and testbench

- Control sequencer sitting directly upstream of the 4x4 systolic-array top level. Drives every control port of that top level: input-SRAM enable, write and address; array input and output enables; output-SRAM enable, write and address.
- Runs one matrix tile per start pulse: stream skewed operand words from the input SRAM, drain the array, store accumulator rows into the output SRAM.
- When idle, forwards host load/readback accesses to the SRAMs.

---
 rtl/sys44_seq.sv | 203 ++++++++++++++++++++
 tb/tb_sys44_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sys44_seq.sv
// sys44_seq -- control sequencer for the 4x4 systolic-array top level.
//
// Runs one matrix tile per start pulse:
//   FEED  : read FEED_LEN operand words from the input SRAM (in_base + k)
//   DRAIN : DRAIN_LEN idle cycles while the array finishes
//   STORE : STORE_LEN accumulator rows written to the output SRAM (out_base + j)
//   DONE  : last output write, one-cycle done pulse
// In IDLE, host accesses are forwarded, one cycle later, to the SRAM ports.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start, abort             job request (IDLE only) / job cancel
//   in_base, out_base        tile base addresses, latched at start
//   host_cs_in/out, host_wr, host_addr   host SRAM access while idle
//   busy, done, host_rej     status; host_rej flags a dropped host access
//   input_en_ramin, wr_in, adder_in      input-SRAM control
//   input_en_sys, output_en_sys          array operand-valid / accout enable
//   input_en_ramout, wr_out, adder_out   output-SRAM control
//   cycles_last              (SYS44_PERF_CNT_EN only) busy cycles of last job
//
// Optional feature macro: SYS44_PERF_CNT_EN.
module sys44_seq #(
  parameter int ADDR_W    = 11,
  parameter int FEED_LEN  = 10,
  parameter int DRAIN_LEN = 4,
  parameter int STORE_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic              host_cs_in,
  input  logic              host_cs_out,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              busy,
  output logic              done,
  output logic              host_rej,
  output logic              input_en_ramin,
  output logic              wr_in,
  output logic [ADDR_W-1:0] adder_in,
  output logic              input_en_sys,
  output logic              output_en_sys,
  output logic              input_en_ramout,
  output logic              wr_out,
  output logic [ADDR_W-1:0] adder_out
`ifdef SYS44_PERF_CNT_EN
  ,
  output logic [15:0]       cycles_last
`endif
);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, STORE, DONE} state_t;

  localparam logic [7:0] FEED_LAST  = 8'(FEED_LEN - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_LEN - 1);
  localparam logic [7:0] STORE_LAST = 8'(STORE_LEN - 1);

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] in_base_q, in_base_n, out_base_q;
  logic              launch;
  logic              host_fwd;
  logic              store_wr;
  logic              feed_rd;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    in_base_n = in_base_q;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          launch    = 1'b1;
          state_n   = FEED;
          cnt_n     = '0;
          in_base_n = in_base;
        end
      end
      FEED: begin
        if (cnt == FEED_LAST) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_n = STORE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      STORE: begin
        if (cnt == STORE_LAST) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  // Host traffic passes only in a quiet IDLE cycle; a start in the same
  // cycle takes priority and the access is dropped.
  assign host_fwd = (state == IDLE) && !launch;
  // Delayed strobes are killed by abort so nothing trails a cancelled job.
  assign feed_rd  = (state == FEED) && !abort;
  assign store_wr = (state == STORE) && !abort;

  // host_rej must flag the very cycle of the dropped access, so it is the
  // one output built from inputs (gated by registered state) rather than a flop.
  assign host_rej = !rst && (host_cs_in || host_cs_out) && ((state != IDLE) || launch);

  // Outputs are registered from the next-state view, so they line up with
  // the state the sequencer is in during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      in_base_q       <= '0;
      out_base_q      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      input_en_ramin  <= 1'b0;
      wr_in           <= 1'b0;
      adder_in        <= '0;
      input_en_sys    <= 1'b0;
      output_en_sys   <= 1'b0;
      input_en_ramout <= 1'b0;
      wr_out          <= 1'b0;
      adder_out       <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      in_base_q  <= in_base_n;
      if (launch) out_base_q <= out_base;

      busy           <= (state_n != IDLE);
      done           <= (state_n == DONE);
      input_en_ramin <= (state_n == FEED) || (host_fwd && host_cs_in);
      wr_in          <= host_fwd && host_cs_in && host_wr;
      if (state_n == FEED)
        adder_in <= in_base_n + ADDR_W'(cnt_n);
      else if (host_fwd && host_cs_in)
        adder_in <= host_addr;
      else
        adder_in <= '0;

      input_en_sys  <= feed_rd;
      output_en_sys <= (state_n == STORE);

      input_en_ramout <= store_wr || (host_fwd && host_cs_out);
      wr_out          <= store_wr || (host_fwd && host_cs_out && host_wr);
      if (store_wr)
        adder_out <= out_base_q + ADDR_W'(cnt);
      else if (host_fwd && host_cs_out)
        adder_out <= host_addr;
      else
        adder_out <= '0;
    end
  end

`ifdef SYS44_PERF_CNT_EN
  logic [15:0] perf_cnt, perf_inc;

  assign perf_inc = (perf_cnt == 16'hFFFF) ? perf_cnt : perf_cnt + 16'd1;

  // The DONE cycle itself is busy, so the copied value includes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt    <= '0;
      cycles_last <= '0;
    end else begin
      if (launch)
        perf_cnt <= '0;
      else if (busy)
        perf_cnt <= perf_inc;
      if (state == DONE && !abort)
        cycles_last <= perf_inc;
    end
  end
`endif

endmodule

// File: tb/tb_sys44_seq.sv
module tb_sys44_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [10:0] in_base, out_base, host_addr;
  logic        host_cs_in, host_cs_out, host_wr;
  logic        busy, done, host_rej;
  logic        input_en_ramin, wr_in, input_en_sys, output_en_sys;
  logic        input_en_ramout, wr_out;
  logic [10:0] adder_in, adder_out;
`ifdef SYS44_PERF_CNT_EN
  logic [15:0] cycles_last;
`endif

  int unsigned n_vec = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  sys44_seq #(
    .ADDR_W(11), .FEED_LEN(10), .DRAIN_LEN(4), .STORE_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_base(in_base), .out_base(out_base),
    .host_cs_in(host_cs_in), .host_cs_out(host_cs_out),
    .host_wr(host_wr), .host_addr(host_addr),
    .busy(busy), .done(done), .host_rej(host_rej),
    .input_en_ramin(input_en_ramin), .wr_in(wr_in), .adder_in(adder_in),
    .input_en_sys(input_en_sys), .output_en_sys(output_en_sys),
    .input_en_ramout(input_en_ramout), .wr_out(wr_out), .adder_out(adder_out)
`ifdef SYS44_PERF_CNT_EN
    , .cycles_last(cycles_last)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0; host_cs_in = 0; host_cs_out = 0; host_wr = 0; host_addr = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".ramin"}, 32'(input_en_ramin), 0);
    chk({tag, ".wr_in"}, 32'(wr_in), 0);
    chk({tag, ".adder_in"}, 32'(adder_in), 0);
    chk({tag, ".en_sys"}, 32'(input_en_sys), 0);
    chk({tag, ".out_en_sys"}, 32'(output_en_sys), 0);
    chk({tag, ".ramout"}, 32'(input_en_ramout), 0);
    chk({tag, ".wr_out"}, 32'(wr_out), 0);
    chk({tag, ".adder_out"}, 32'(adder_out), 0);
  endtask

  // Start a job in the current cycle T and check cycles T+1..T+22.
  // abort_at: cycle at which abort is raised (0 = none).
  // inj: host access with the start, host write at T+5, extra start at T+7.
  task automatic run_job(input logic [10:0] ib, input logic [10:0] ob,
                         input int abort_at, input bit inj);
    bit          live;
    logic [10:0] ea;
    start = 1; in_base = ib; out_base = ob;
    if (inj) begin host_cs_out = 1; host_wr = 1; host_addr = 11'h123; end
    #1;
    if (inj) chk("rej_with_start", 32'(host_rej), 1);
    for (int c = 1; c <= 22; c++) begin
      step();
      clear_inputs();
      in_base = ~ib; out_base = ~ob;
      live = (abort_at == 0) || (c <= abort_at);
      chk($sformatf("busy@%0d", c), 32'(busy), 32'(live && c <= 19));
      chk($sformatf("done@%0d", c), 32'(done), 32'(live && c == 19));
      chk($sformatf("ramin@%0d", c), 32'(input_en_ramin), 32'(live && c <= 10));
      chk($sformatf("wr_in@%0d", c), 32'(wr_in), 0);
      ea = 11'(ib + 11'(c - 1));
      chk($sformatf("adder_in@%0d", c), 32'(adder_in), (live && c <= 10) ? 32'(ea) : 0);
      chk($sformatf("en_sys@%0d", c), 32'(input_en_sys), 32'(live && c >= 2 && c <= 11));
      chk($sformatf("out_en_sys@%0d", c), 32'(output_en_sys), 32'(live && c >= 15 && c <= 18));
      chk($sformatf("ramout@%0d", c), 32'(input_en_ramout), 32'(live && c >= 16 && c <= 19));
      chk($sformatf("wr_out@%0d", c), 32'(wr_out), 32'(live && c >= 16 && c <= 19));
      ea = 11'(ob + 11'(c - 16));
      chk($sformatf("adder_out@%0d", c), 32'(adder_out),
          (live && c >= 16 && c <= 19) ? 32'(ea) : 0);
      if (inj && c == 5) begin host_cs_in = 1; host_wr = 1; host_addr = 11'h055; end
      if (inj && c == 7) start = 1;
      if (c == abort_at) abort = 1;
      #1;
      chk($sformatf("host_rej@%0d", c), 32'(host_rej), 32'(inj && c == 5));
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1; clear_inputs(); in_base = '0; out_base = '0;
    step(); step();
    chk_all_zero("reset");
`ifdef SYS44_PERF_CNT_EN
    chk("reset.cycles_last", 32'(cycles_last), 0);
`endif
    rst = 0;
    step();

    // Host load of words 0..9 into the input SRAM
    for (int i = 0; i < 10; i++) begin
      host_cs_in = 1; host_wr = 1; host_addr = 11'(i);
      #1 chk("load.rej", 32'(host_rej), 0);
      step();
      chk("load.ramin", 32'(input_en_ramin), 1);
      chk("load.wr_in", 32'(wr_in), 1);
      chk("load.adder_in", 32'(adder_in), 32'(i));
      chk("load.ramout", 32'(input_en_ramout), 0);
    end
    // Host readback from the output SRAM
    host_cs_in = 0; host_cs_out = 1; host_wr = 0; host_addr = 11'h321;
    step();
    chk("rd.ramout", 32'(input_en_ramout), 1);
    chk("rd.wr_out", 32'(wr_out), 0);
    chk("rd.adder_out", 32'(adder_out), 32'h321);
    chk("rd.ramin", 32'(input_en_ramin), 0);
    clear_inputs();
    step();

    // Default job
    run_job(11'h000, 11'h020, 0, 1'b0);
`ifdef SYS44_PERF_CNT_EN
    chk("perf.job", 32'(cycles_last), 19);
`endif

    // Address wrap on both sides
    run_job(11'h7FC, 11'h7FE, 0, 1'b0);

    // Busy rejection and ignored start
    run_job(11'h010, 11'h040, 0, 1'b1);

    // Abort in STORE, then a normal job
    run_job(11'h000, 11'h020, 16, 1'b0);
`ifdef SYS44_PERF_CNT_EN
    chk("perf.abort", 32'(cycles_last), 19);
`endif
    run_job(11'h100, 11'h200, 0, 1'b0);

    // Reset mid-FEED
    start = 1; in_base = 11'h0AA; out_base = 11'h055;
    step(); start = 0;
    step(); step(); step();
    chk("pre_rst.busy", 32'(busy), 1);
    chk("pre_rst.adder_in", 32'(adder_in), 32'h0AD);
    rst = 1;
    step();
    rst = 0;
    chk_all_zero("rst_mid");
    step();
    chk("rst_mid.idle", 32'(busy), 0);

    // start and abort together in IDLE
    start = 1; abort = 1;
    step();
    clear_inputs();
    chk("st_ab.busy", 32'(busy), 0);
    chk("st_ab.ramin", 32'(input_en_ramin), 0);
    step();
    chk("st_ab.busy2", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
